mmio_interconnect: RTL and testbench
====================================

// Module: mmio_interconnect
// PURPOSE
//  Parametrised CPU-to-peripheral bus fabric between processor and memory/display/UART/future slaves.
//  Decodes address into 4 KiB regions; runs a req/ready handshake per slave (wait states allowed).
//  Aborts hung slaves by timeout and traps unmapped accesses.
//  Built-in status region exposes sticky error flags, the faulting address and an error count.
// PARAMETERS
//  NUM_SLAVES      4    external slaves; slave i owns region i (0..NUM_SLAVES-1)
//  ADDR_W          32   CPU address width
//  REGION_LSB      12   lowest region-select bit (region size 2**REGION_LSB bytes)
//  REGION_W        4    region-select bits -> addr[REGION_LSB+REGION_W-1:REGION_LSB]
//  STATUS_REGION   15   internal status region index; must be >= NUM_SLAVES
//  TIMEOUT_CYCLES  255  max WAIT cycles before abort; >= 1
// PORTS
//  clk          in   1               single clock, all logic on posedge
//  reset_n_i    in   1               synchronous reset, active-low
//  req_i        in   1               CPU request, sampled only in IDLE
//  addr_i       in   ADDR_W          byte address
//  we_i         in   1               1 = write, 0 = read
//  wr_mask_i    in   4               byte enables for writes
//  wdata_i      in   32              write data
//  rdata_o      out  32              read data, valid while ready_o = 1
//  ready_o      out  1               one-cycle response pulse
//  err_o        out  1               qualifies ready_o: access failed (unmapped/timeout)
//  busy_o       out  1               1 while not IDLE
//  sl_sel_o     out  NUM_SLAVES      one-hot slave select, held until slave ready
//  sl_we_o      out  1               registered we
//  sl_addr_o    out  REGION_LSB      in-region byte offset
//  sl_wmask_o   out  4               registered byte enables
//  sl_wdata_o   out  32              registered write data
//  sl_rdata_i   in   32*NUM_SLAVES   packed; slave i at [32*i+:32]
//  sl_ready_i   in   NUM_SLAVES      slave i completes the access this cycle
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge): state IDLE.
//   rdata_o, ready_o, err_o, busy_o, sl_sel_o, sl_we_o, sl_addr_o, sl_wmask_o, sl_wdata_o all 0.
//   Status regs cleared. Mid-transaction reset drops sl_sel_o next edge; no ready_o emitted.
//  FSM (mmio_pkg::state_t): IDLE, WAIT, RESP.
//   IDLE: req_i=1 latches addr/we/mask/wdata.
//    External region -> WAIT, sl_sel_o one-hot, timeout counter=0.
//    STATUS_REGION or unmapped region -> RESP directly.
//    req_i while busy_o=1 is ignored (CPU holds req until ready_o).
//   WAIT: sl_sel_o and sl_* stable.
//    sl_ready_i[sel]=1 -> capture sl_rdata_i slice (reads; writes capture 0); drop sel; go RESP.
//    Counter reaches TIMEOUT_CYCLES first -> abort: drop sel, set TIMEOUT flag, go RESP with err.
//    Ready and timeout on the same cycle: ready wins, no error.
//    sl_ready_i of unselected slaves ignored.
//   RESP: ready_o=1 for exactly one cycle; err_o as decided; then IDLE.
//  Latency: min req_i -> ready_o = 2 cycles for a zero-wait slave; internal/unmapped = 1 cycle.
//  Unmapped access: reads return 0; writes have no effect; err_o=1; UNMAPPED flag set.
//  Status region (offset = addr[REGION_LSB-1:0]; other offsets read 0, writes ignored):
//   0x0 ERR_FLAGS  bit0 UNMAPPED, bit1 TIMEOUT; sticky; write-1-to-clear with wr_mask_i[0].
//   0x4 ERR_ADDR   full address of most recent error; read-only.
//   0x8 ERR_COUNT  8-bit error counter, saturates at 255; any write clears it.
//  Simultaneous W1C and new error on one edge cannot occur (single outstanding access);
//   set still has priority by construction.
//  Status accesses never set err_o.
// STRUCTURE
//  mmio_pkg: state_t enum; ERR_UNMAPPED_BIT=0, ERR_TIMEOUT_BIT=1;
//   STAT_FLAGS=12'h0, STAT_ADDR=12'h4, STAT_COUNT=12'h8.
//  Sub-module mmio_status_regs: flag/addr/count registers, W1C and saturation logic.
//  Top holds decoder, FSM, timeout counter ($clog2(TIMEOUT_CYCLES+1) bits), response regs.
// TESTING
//  Write 0xA5 to 0x1000, slave1 ready same cycle -> sl_sel_o=4'b0010 one cycle; ready_o 2 cycles after req, err_o=0.
//  Read 0x2004, slave2 ready after 3 wait cycles with rdata 0x2 -> rdata_o=0x2, ready_o on cycle 5.
//  Read 0x0000_3000, slave3 never ready, TIMEOUT_CYCLES=8 -> ready_o+err_o after 8 WAIT cycles; sl_sel_o drops.
//   Then ERR_FLAGS reads 0x2, ERR_ADDR 0x3000.
//  Read 0x9000 (region 9, unmapped) -> rdata_o=0, err_o=1 after 1 cycle; ERR_FLAGS=0x1, ERR_COUNT=1.
//  Write 0x3 to 0xF000, then 256 unmapped accesses -> ERR_FLAGS=0 after W1C; ERR_COUNT saturates at 0xFF.
//  Assert reset_n_i=0 during WAIT -> next edge all outputs 0, no ready_o.
//   First post-reset read of slave0 completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect: FSM states, error flag
// bit positions and status-register offsets.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ERR_UNMAPPED_BIT = 0;
    localparam int ERR_TIMEOUT_BIT  = 1;

    localparam logic [11:0] STAT_FLAGS = 12'h0;
    localparam logic [11:0] STAT_ADDR  = 12'h4;
    localparam logic [11:0] STAT_COUNT = 12'h8;

endpackage

// File: rtl/mmio_status_regs.sv
// Sticky error flags, last faulting address and saturating error counter,
// exposed through the interconnect's internal status region.
module mmio_status_regs
    import mmio_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REGION_LSB = 12
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic                  set_unmapped_i,
    input  logic                  set_timeout_i,
    input  logic [ADDR_W-1:0]     err_addr_i,
    input  logic                  wr_en_i,
    input  logic [REGION_LSB-1:0] off_i,
    input  logic                  wr_mask0_i,
    input  logic [1:0]            wr_clr_i,
    output logic [31:0]           rd_data_o
);

    logic [1:0]        flags_q, flags_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [7:0]        count_q, count_d;

    always_comb begin
        flags_d    = flags_q;
        err_addr_d = err_addr_q;
        count_d    = count_q;

        if (wr_en_i && off_i == REGION_LSB'(STAT_FLAGS) && wr_mask0_i) begin
            flags_d = flags_q & ~wr_clr_i;
        end
        if (wr_en_i && off_i == REGION_LSB'(STAT_COUNT)) begin
            count_d = 8'h00;
        end

        // Error set is applied last so it overrides a clear on the same edge.
        if (set_unmapped_i) begin
            flags_d[ERR_UNMAPPED_BIT] = 1'b1;
        end
        if (set_timeout_i) begin
            flags_d[ERR_TIMEOUT_BIT] = 1'b1;
        end
        if (set_unmapped_i || set_timeout_i) begin
            err_addr_d = err_addr_i;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'h01;
            end
        end
    end

    always_comb begin
        rd_data_o = 32'h0;
        if (off_i == REGION_LSB'(STAT_FLAGS)) begin
            rd_data_o = {30'h0, flags_q};
        end else if (off_i == REGION_LSB'(STAT_ADDR)) begin
            rd_data_o = 32'(err_addr_q);
        end else if (off_i == REGION_LSB'(STAT_COUNT)) begin
            rd_data_o = {24'h0, count_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            flags_q    <= '0;
            err_addr_q <= '0;
            count_q    <= '0;
        end else begin
            flags_q    <= flags_d;
            err_addr_q <= err_addr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// CPU-to-peripheral bus fabric: region decode, per-slave req/ready handshake with
// timeout abort, unmapped-access trapping and an internal status region.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_W         = 32,
    parameter int REGION_LSB     = 12,
    parameter int REGION_W       = 4,
    parameter int STATUS_REGION  = 15,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     req_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     we_i,
    input  logic [3:0]               wr_mask_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     ready_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [NUM_SLAVES-1:0]    sl_sel_o,
    output logic                     sl_we_o,
    output logic [REGION_LSB-1:0]    sl_addr_o,
    output logic [3:0]               sl_wmask_o,
    output logic [31:0]              sl_wdata_o,
    input  logic [32*NUM_SLAVES-1:0] sl_rdata_i,
    input  logic [NUM_SLAVES-1:0]    sl_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [REGION_W-1:0]   region;
    logic [31:0]           sel_rdata;
    logic [31:0]           stat_rdata;
    logic                  set_unmapped;
    logic                  set_timeout;
    logic                  stat_wr;
    logic [ADDR_W-1:0]     err_addr;

    assign region = addr_i[REGION_LSB+REGION_W-1:REGION_LSB];

    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | sl_rdata_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        set_unmapped = 1'b0;
        set_timeout  = 1'b0;
        stat_wr      = 1'b0;
        err_addr     = addr_q;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wmask_d = wr_mask_i;
                    wdata_d = wdata_i;
                    if (int'(region) < NUM_SLAVES) begin
                        state_d = WAIT;
                        sel_d   = NUM_SLAVES'(1) << region;
                        cnt_d   = '0;
                    end else if (int'(region) == STATUS_REGION) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        stat_wr = we_i;
                        rdata_d = we_i ? 32'h0 : stat_rdata;
                    end else begin
                        state_d      = RESP;
                        ready_d      = 1'b1;
                        err_d        = 1'b1;
                        rdata_d      = 32'h0;
                        set_unmapped = 1'b1;
                        err_addr     = addr_i;
                    end
                end
            end
            WAIT: begin
                // Ready is tested before the timeout so a same-cycle ready wins.
                if ((sl_ready_i & sel_q) != '0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    ready_d     = 1'b1;
                    err_d       = 1'b1;
                    sel_d       = '0;
                    rdata_d     = 32'h0;
                    set_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    mmio_status_regs #(
        .ADDR_W     (ADDR_W),
        .REGION_LSB (REGION_LSB)
    ) u_status (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .set_unmapped_i (set_unmapped),
        .set_timeout_i  (set_timeout),
        .err_addr_i     (err_addr),
        .wr_en_i        (stat_wr),
        .off_i          (addr_i[REGION_LSB-1:0]),
        .wr_mask0_i     (wr_mask_i[0]),
        .wr_clr_i       (wdata_i[1:0]),
        .rd_data_o      (stat_rdata)
    );

    assign rdata_o    = rdata_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);
    assign sl_sel_o   = sel_q;
    assign sl_we_o    = we_q;
    assign sl_addr_o  = addr_q[REGION_LSB-1:0];
    assign sl_wmask_o = wmask_q;
    assign sl_wdata_o = wdata_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Self-checking bench for mmio_interconnect: directed vector table, randomized
// accesses against a transaction-level reference model, and reset corner cases.
module tb_mmio_interconnect;

    localparam int TO = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          req_i;
    logic [31:0]   addr_i;
    logic          we_i;
    logic [3:0]    wr_mask_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          ready_o;
    logic          err_o;
    logic          busy_o;
    logic [NS-1:0] sl_sel_o;
    logic          sl_we_o;
    logic [11:0]   sl_addr_o;
    logic [3:0]    sl_wmask_o;
    logic [31:0]   sl_wdata_o;
    logic [32*NS-1:0] sl_rdata_i;
    logic [NS-1:0] sl_ready_i;

    mmio_interconnect #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (32),
        .REGION_LSB     (12),
        .REGION_W       (4),
        .STATUS_REGION  (15),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .wr_mask_i  (wr_mask_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .sl_sel_o   (sl_sel_o),
        .sl_we_o    (sl_we_o),
        .sl_addr_o  (sl_addr_o),
        .sl_wmask_o (sl_wmask_o),
        .sl_wdata_o (sl_wdata_o),
        .sl_rdata_i (sl_rdata_i),
        .sl_ready_i (sl_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the status region should hold.
    logic [1:0]  m_flags;
    logic [31:0] m_eaddr;
    logic [7:0]  m_count;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = 2'b00;
        m_eaddr = 32'h0;
        m_count = 8'h00;
    endtask

    task automatic model_err(input logic [31:0] addr, input int bitpos);
        m_flags[bitpos] = 1'b1;
        m_eaddr = addr;
        if (m_count != 8'hFF) m_count = m_count + 8'h01;
    endtask

    // Transaction-level prediction of one access and its effect on the status region.
    task automatic model(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                         input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output logic chk_rd);
        int reg_n;
        logic [11:0] off;
        reg_n = int'(addr[15:12]);
        off = addr[11:0];
        rdata = 32'h0;
        err = 1'b0;
        chk_rd = 1'b0;
        if (reg_n < NS) begin
            if (delay >= 0 && delay < TO) begin
                lat = delay + 2;
                rdata = we ? 32'h0 : sdata;
                chk_rd = 1'b1;
            end else begin
                lat = TO + 1;
                err = 1'b1;
                model_err(addr, 1);
            end
        end else if (reg_n == 15) begin
            lat = 1;
            if (!we) begin
                chk_rd = 1'b1;
                if (off == 12'h0) rdata = {30'h0, m_flags};
                else if (off == 12'h4) rdata = m_eaddr;
                else if (off == 12'h8) rdata = {24'h0, m_count};
            end else begin
                if (off == 12'h0 && mask[0]) m_flags = m_flags & ~wdata[1:0];
                if (off == 12'h8) m_count = 8'h00;
            end
        end else begin
            lat = 1;
            err = 1'b1;
            chk_rd = !we;
            model_err(addr, 0);
        end
    endtask

    task automatic run_access(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                              input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                              output int lat, output logic err, output logic [31:0] rdata,
                              output logic bus_ok);
        int tgt;
        logic [NS-1:0] tm;
        logic [NS-1:0] noise;
        logic done;
        tgt = int'(addr[15:12]);
        tm = (tgt < NS) ? NS'(1) << tgt : '0;
        @(negedge clk);
        req_i = 1'b1;
        addr_i = addr;
        we_i = we;
        wr_mask_i = mask;
        wdata_i = wdata;
        for (int i = 0; i < NS; i++) sl_rdata_i[32*i +: 32] = $urandom;
        if (tgt < NS) sl_rdata_i[32*tgt +: 32] = sdata;
        noise = NS'($urandom);
        sl_ready_i = noise & ~tm;
        lat = 0;
        err = 1'b0;
        rdata = 32'h0;
        bus_ok = 1'b1;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (!busy_o) bus_ok = 1'b0;
            if (ready_o) begin
                done = 1'b1;
                err = err_o;
                rdata = rdata_o;
                if (sl_sel_o != '0) bus_ok = 1'b0;
            end else begin
                if (tgt < NS) begin
                    if (sl_sel_o != tm || sl_we_o != we || sl_addr_o != addr[11:0] ||
                        sl_wmask_o != mask || sl_wdata_o != wdata) bus_ok = 1'b0;
                end
                noise = NS'($urandom) & ~tm;
                if (tgt < NS && delay >= 0 && lat == delay + 1) noise = noise | tm;
                sl_ready_i = noise;
            end
        end
        req_i = 1'b0;
        sl_ready_i = '0;
        if (!done) lat = -1;
    endtask

    task automatic do_vec(input string name, input vec_t v, input logic use_tbl);
        int lat, m_lat;
        logic err, m_err, bus_ok, m_chk;
        logic [31:0] rdata, m_rdata;
        model(v.addr, v.we, v.mask, v.wdata, v.delay, v.sdata, m_lat, m_err, m_rdata, m_chk);
        if (use_tbl) begin
            m_lat = v.lat;
            m_err = v.err;
            m_rdata = v.rdata;
            m_chk = v.chk_rd;
        end
        run_access(v.addr, v.we, v.mask, v.wdata, v.delay, v.sdata, lat, err, rdata, bus_ok);
        check({name, "_latency"}, 32'(lat), 32'(m_lat));
        check({name, "_err"}, {31'h0, err}, {31'h0, m_err});
        check({name, "_bus"}, {31'h0, bus_ok}, 32'h1);
        if (m_chk) check({name, "_rdata"}, rdata, m_rdata);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                                input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                                input int lat, input logic err, input logic [31:0] rdata,
                                input logic chk_rd);
        vec_t v;
        v.addr = addr; v.we = we; v.mask = mask; v.wdata = wdata; v.delay = delay;
        v.sdata = sdata; v.lat = lat; v.err = err; v.rdata = rdata; v.chk_rd = chk_rd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int lat;
        logic err, bus_ok;
        logic [31:0] rdata;
        logic [31:0] r;
        int kind;

        tbl[0]  = mk(32'h0000_1000, 1, 4'hF, 32'hA5,        0, 32'h1111, 2,  0, 32'h0,       1);
        tbl[1]  = mk(32'h0000_2004, 0, 4'h0, 32'h0,         3, 32'h2,    5,  0, 32'h2,       1);
        tbl[2]  = mk(32'h0000_3000, 0, 4'h0, 32'h0,        -1, 32'h7,    9,  1, 32'h0,       0);
        tbl[3]  = mk(32'h0000_F000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h2,       1);
        tbl[4]  = mk(32'h0000_F004, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h3000,    1);
        tbl[5]  = mk(32'h0000_F008, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h1,       1);
        tbl[6]  = mk(32'h0000_F000, 1, 4'h1, 32'h3,         0, 32'h0,    1,  0, 32'h0,       0);
        tbl[7]  = mk(32'h0000_F000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h0,       1);
        tbl[8]  = mk(32'h0000_9000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  1, 32'h0,       1);
        tbl[9]  = mk(32'h0000_F000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h1,       1);
        tbl[10] = mk(32'h0000_F008, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h2,       1);
        tbl[11] = mk(32'h0000_F004, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h9000,    1);
        tbl[12] = mk(32'h0000_0010, 0, 4'h0, 32'h0,         7, 32'hDEADBEEF, 9, 0, 32'hDEADBEEF, 1);
        tbl[13] = mk(32'h0000_F000, 1, 4'hE, 32'h3,         0, 32'h0,    1,  0, 32'h0,       0);
        tbl[14] = mk(32'h0000_F000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h1,       1);
        tbl[15] = mk(32'h0000_F00C, 1, 4'hF, 32'hFFFFFFFF,  0, 32'h0,    1,  0, 32'h0,       0);
        tbl[16] = mk(32'h0000_F00C, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h0,       1);
        tbl[17] = mk(32'h0000_F008, 1, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h0,       0);
        tbl[18] = mk(32'h0000_F008, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h0,       1);
        tbl[19] = mk(32'h0000_4000, 1, 4'hF, 32'h1,         0, 32'h0,    1,  1, 32'h0,       0);
        tbl[20] = mk(32'h0000_F000, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h1,       1);
        tbl[21] = mk(32'h0000_F004, 0, 4'h0, 32'h0,         0, 32'h0,    1,  0, 32'h4000,    1);

        reset_n_i = 1'b0;
        req_i = 1'b0;
        addr_i = '0;
        we_i = 1'b0;
        wr_mask_i = '0;
        wdata_i = '0;
        sl_rdata_i = '0;
        sl_ready_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {31'h0, |{rdata_o, ready_o, err_o, busy_o, sl_sel_o, sl_we_o,
                                          sl_addr_o, sl_wmask_o, sl_wdata_o}}, 32'h0);
        reset_n_i = 1'b1;

        for (int i = 0; i < 22; i++) do_vec($sformatf("vec%0d", i), tbl[i], 1'b1);

        // Saturation: 256 unmapped accesses on top of the one already counted.
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            v = mk({r[31:16], 4'($urandom_range(4, 14)), r[11:0]}, r[0], r[7:4], r, 0, 32'h0,
                   0, 0, 32'h0, 0);
            do_vec("unmapped", v, 1'b0);
        end
        run_access(32'h0000_F008, 0, 4'h0, 32'h0, 0, 32'h0, lat, err, rdata, bus_ok);
        check("count_saturated", rdata, 32'hFF);

        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                v = mk({r[31:16], 4'($urandom_range(0, NS - 1)), r[11:2], 2'b00}, r[3], r[7:4],
                       $urandom, $urandom_range(0, 10), $urandom, 0, 0, 32'h0, 0);
                if (r[8] && r[9] && r[10]) v.delay = -1;
            end else if (kind <= 7) begin
                v = mk({r[31:16], 4'hF, 8'h00, 2'($urandom_range(0, 3)), 2'b00},
                       ($urandom_range(0, 3) == 0), r[7:4], $urandom, 0, 32'h0, 0, 0, 32'h0, 0);
            end else begin
                v = mk({r[31:16], 4'($urandom_range(4, 14)), r[11:0]}, r[0], r[7:4], r, 0,
                       32'h0, 0, 0, 32'h0, 0);
            end
            do_vec("random", v, 1'b0);
        end

        // Reset while a slave is stalling: everything drops, no response appears.
        @(negedge clk);
        req_i = 1'b1;
        addr_i = 32'h0000_0040;
        we_i = 1'b0;
        sl_ready_i = '0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'h0, busy_o}, 32'h1);
        check("pre_reset_sel", {28'h0, sl_sel_o}, 32'h1);
        reset_n_i = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {31'h0, |{rdata_o, ready_o, err_o, busy_o, sl_sel_o, sl_we_o,
                                             sl_addr_o, sl_wmask_o, sl_wdata_o}}, 32'h0);
        reset_n_i = 1'b1;
        model_reset();
        @(negedge clk);
        check("post_reset_no_ready", {31'h0, ready_o}, 32'h0);
        v = mk(32'h0000_0080, 0, 4'h0, 32'h0, 1, 32'hCAFE_0001, 3, 0, 32'hCAFE_0001, 1);
        do_vec("post_reset_read", v, 1'b1);
        v = mk(32'h0000_F000, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1);
        do_vec("post_reset_flags", v, 1'b1);
        v = mk(32'h0000_F008, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1);
        do_vec("post_reset_count", v, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
